// File: rtl/mux_scan_ctrl_if.sv
// Signal bundle between the channel scanner, the 4x1 mux and the frame consumer.
// The slave modport is the scanner's view; the master modport is the surrounding logic's view.
interface mux_scan_ctrl_if;
    localparam int unsigned NumCh = 4;
    localparam int unsigned SelW  = 2;

    logic              start;
    logic [NumCh-1:0]  mask;
    logic              mux_out;
    logic [SelW-1:0]   sel;
    logic [NumCh-1:0]  frame;
    logic              frame_valid;
    logic              frame_ready;
    logic              busy;

    modport master (
        output start, mask, mux_out, frame_ready,
        input  sel, frame, frame_valid, busy
    );

    modport slave (
        input  start, mask, mux_out, frame_ready,
        output sel, frame, frame_valid, busy
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Steps the mux select through the enabled channels in ascending order, samples each after DWELL cycles,
// and hands the assembled 4-bit frame to a valid/ready consumer.
module mux_scan_ctrl #(
    parameter int unsigned DWELL = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    mux_scan_ctrl_if.slave  bus
);
    localparam int unsigned NumCh = 4;
    localparam int unsigned SelW  = 2;
    localparam int unsigned CntW  = 8;
    localparam logic [CntW-1:0] DwellLast = CntW'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e            state_q;
    logic [SelW-1:0]   sel_q;
    logic [NumCh-1:0]  frame_q;
    logic              frame_valid_q;
    logic              busy_q;
    logic [CntW-1:0]   cnt_q;
    logic [NumCh-1:0]  mask_q;
    logic [NumCh-1:0]  buf_q;

    logic [SelW-1:0]   first_sel_c;
    logic [SelW-1:0]   next_sel_c;
    logic              has_next_c;
    logic [NumCh-1:0]  buf_upd_c;

    // Lowest enabled channel of the incoming mask (descending scan so the lowest wins).
    always_comb begin
        first_sel_c = '0;
        for (int i = int'(NumCh) - 1; i >= 0; i--) begin
            if (bus.mask[SelW'(i)]) first_sel_c = SelW'(i);
        end
    end

    // Next enabled channel strictly above the current select, from the latched mask.
    always_comb begin
        has_next_c = 1'b0;
        next_sel_c = sel_q;
        for (int i = int'(NumCh) - 1; i >= 0; i--) begin
            if (mask_q[SelW'(i)] && (i > int'(sel_q))) begin
                has_next_c = 1'b1;
                next_sel_c = SelW'(i);
            end
        end
    end

    // Sample buffer including the bit captured on the current edge.
    always_comb begin
        buf_upd_c        = buf_q;
        buf_upd_c[sel_q] = bus.mux_out;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            sel_q         <= '0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            cnt_q         <= '0;
            mask_q        <= '0;
            buf_q         <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start && (bus.mask != '0)) begin
                        mask_q  <= bus.mask;
                        buf_q   <= '0;
                        sel_q   <= first_sel_c;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt_q == DwellLast) begin
                        buf_q <= buf_upd_c;
                        cnt_q <= '0;
                        if (has_next_c) begin
                            sel_q <= next_sel_c;
                        end else begin
                            frame_q       <= buf_upd_c;
                            frame_valid_q <= 1'b1;
                            state_q       <= DONE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                DONE: begin
                    if (bus.frame_ready) begin
                        frame_valid_q <= 1'b0;
                        busy_q        <= 1'b0;
                        state_q       <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.sel         = sel_q;
    assign bus.frame       = frame_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.busy        = busy_q;
endmodule
